data_bram_reader: RTL and testbench

Read-side initiator for the accelerator's data BRAM port. On a start command, issues a run of consecutive word addresses to the BRAM and captures each returned word, accounting for its one-cycle registered read latency. It then serializes each word into bytes on a valid/ready stream toward the PE input buffers. The block is the requester paired with the BRAM responder (drives `ordaddr`, consumes `irddat`).

---
 rtl/dnn_accel_pkg.sv | 25 ++
 rtl/data_bram_reader_if.sv | 31 +++
 rtl/data_word_unpacker.sv | 74 +++++++
 rtl/data_bram_reader.sv | 118 +++++++++++
 tb/tb_data_bram_reader.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dnn_accel_pkg.sv
// Shared definitions for the accelerator data path: default widths,
// reader FSM state encoding and the bytes-per-word helper.
package dnn_accel_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int BYTE_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF  = 16;

  // Number of output elements carried by one BRAM word
  function automatic int calc_bytes_per_word(input int dw, input int bw);
    return dw / bw;
  endfunction

  localparam int BYTES_PER_WORD = calc_bytes_per_word(DATA_WIDTH_DEF, BYTE_WIDTH_DEF);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAPT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } rd_state_t;

endpackage

// File: rtl/data_bram_reader_if.sv
// Bundle of the command, BRAM read-port and byte-stream signals of the
// data BRAM reader. master = the reader, slave = its environment.
interface data_bram_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) ();

  logic                  istart;
  logic [ADDR_WIDTH-1:0] ibase;
  logic [LEN_WIDTH-1:0]  ilen;
  logic [ADDR_WIDTH-1:0] ordaddr;
  logic [DATA_WIDTH-1:0] irddat;
  logic [BYTE_WIDTH-1:0] odat;
  logic                  ovalid;
  logic                  iready;
  logic                  obusy;
  logic                  odone;

  modport master (
    input  istart, ibase, ilen, irddat, iready,
    output ordaddr, odat, ovalid, obusy, odone
  );

  modport slave (
    output istart, ibase, ilen, irddat, iready,
    input  ordaddr, odat, ovalid, obusy, odone
  );

endinterface

// File: rtl/data_word_unpacker.sv
// Holds one captured BRAM word and presents it byte by byte (little-endian)
// on a valid/ready stream. Reports when the last byte of the word is taken.
module data_word_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_ready,
  output logic [BYTE_WIDTH-1:0] o_dat,
  output logic                  o_valid,
  output logic                  o_last_acc
);

  // DATA_WIDTH is expected to be an exact multiple of BYTE_WIDTH
  localparam int BPW   = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] r_word;
  logic [IDX_W-1:0]      r_idx;
  logic [BYTE_WIDTH-1:0] r_dat;
  logic                  r_valid;

  logic [BYTE_WIDTH-1:0] w_bytes [BPW];
  logic [IDX_W-1:0]      w_next_idx;
  logic                  w_fire;
  logic                  w_is_last;

  genvar g;
  for (g = 0; g < BPW; g++) begin : g_bytes
    assign w_bytes[g] = r_word[g*BYTE_WIDTH +: BYTE_WIDTH];
  end

  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_fire     = r_valid & i_ready;
  assign w_is_last  = (r_idx == IDX_W'(BPW - 1));

  assign o_dat      = r_dat;
  assign o_valid    = r_valid;
  assign o_last_acc = w_fire & w_is_last;

  // Word load, byte advance on handshake, hold everything under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_dat   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_idx   <= '0;
      r_dat   <= i_word[BYTE_WIDTH-1:0];
      r_valid <= 1'b1;
    end else if (w_fire) begin
      if (w_is_last) begin
        r_idx   <= '0;
        r_dat   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx   <= w_next_idx;
        r_dat   <= w_bytes[w_next_idx];
        r_valid <= 1'b1;
      end
    end else begin
      r_word  <= r_word;
      r_idx   <= r_idx;
      r_dat   <= r_dat;
      r_valid <= r_valid;
    end
  end

endmodule

// File: rtl/data_bram_reader.sv
// Read-side initiator for the data BRAM: walks a run of consecutive word
// addresses, captures each word one cycle after presenting its address,
// and hands it to the unpacker for byte serialization.
module data_bram_reader
  import dnn_accel_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  data_bram_reader_if.master bus
);

  rd_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_load;
  logic                  w_last_acc;
  logic [BYTE_WIDTH-1:0] w_dat;
  logic                  w_valid;

  // The BRAM word is on irddat during CAPT (address was sampled at REQ's closing edge)
  assign w_load = (r_state == ST_CAPT);

  data_word_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_unpacker (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_word     (bus.irddat),
    .i_ready    (bus.iready),
    .o_dat      (w_dat),
    .o_valid    (w_valid),
    .o_last_acc (w_last_acc)
  );

  assign bus.ordaddr = r_addr;
  assign bus.odat    = w_dat;
  assign bus.ovalid  = w_valid;
  assign bus.obusy   = r_busy;
  assign bus.odone   = r_done;

  // Transfer FSM with address/count tracking and registered busy/done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.istart) begin
            if (bus.ilen == '0) begin
              // Empty run: no address is issued, just a completion pulse
              r_remaining <= '0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_addr      <= bus.ibase;
              r_remaining <= bus.ilen;
              r_busy      <= 1'b1;
              r_state     <= ST_REQ;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (w_last_acc) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (r_remaining > LEN_WIDTH'(1)) begin
              // Address wraps modulo 2^ADDR_WIDTH by plain overflow
              r_addr  <= r_addr + ADDR_WIDTH'(1);
              r_state <= ST_REQ;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_state <= ST_EMIT;
          end
        end
        ST_DONE: begin
          // A start seen here is deliberately dropped
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bram_reader.sv
// Directed self-checking bench for data_bram_reader with a one-cycle
// registered BRAM model.
module tb_data_bram_reader;
  import dnn_accel_pkg::*;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_bytes [0:15];
  logic [31:0] exp_addr  [0:3];
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  data_bram_reader_if #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .BYTE_WIDTH (8), .LEN_WIDTH (16)
  ) bus ();

  data_bram_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0020_1000;
      32'h0000_0001: return 32'h1101_2111;
      32'h0000_0002: return 32'h2212_0222;
      32'hFFFF_FFFF: return 32'hAABB_CCDD;
      default:       return 32'hDEAD_0000;
    endcase
  endfunction

  // BRAM model: registered read, data one cycle after the address
  always @(posedge clk) bus.irddat <= mem(bus.ordaddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_word(input int w, input logic [31:0] addr);
    logic [31:0] v;
    v = mem(addr);
    exp_addr[w] = addr;
    for (int b = 0; b < 4; b++) exp_bytes[w*4+b] = v[b*8 +: 8];
  endtask

  task automatic start(input logic [31:0] base, input logic [15:0] len);
    bus.ibase  = base;
    bus.ilen   = len;
    bus.istart = 1'b1;
    step();
    bus.istart = 1'b0;
    bus.ilen   = 16'd5;   // later ilen changes must not matter
  endtask

  // Observe the stream until odone; cycle 0 is the REQ cycle after the start edge
  task automatic collect(input int nwords, input bit bp, input int inj_c,
                         input bit inj_done, input int exp_cycles);
    int k;
    int c;
    bit hold;
    bit seen;
    logic [7:0] pdat;
    k = 0; c = 0; hold = 1'b0; seen = 1'b0; pdat = 8'h00;
    while (!seen && c < 400) begin
      if (hold) begin
        chk("hold_valid", {31'd0, bus.ovalid}, 32'd1);
        chk("hold_dat", {24'd0, bus.odat}, {24'd0, pdat});
      end
      if (bus.odone) begin
        seen = 1'b1;
        chk("done_busy", {31'd0, bus.obusy}, 32'd0);
        chk("done_valid", {31'd0, bus.ovalid}, 32'd0);
        if (exp_cycles >= 0) chk("done_cycle", c, exp_cycles);
      end else if (bus.ovalid) begin
        if (k < nwords*4) begin
          chk("byte", {24'd0, bus.odat}, {24'd0, exp_bytes[k]});
          if (k % 4 == 0) chk("addr", bus.ordaddr, exp_addr[k/4]);
        end else begin
          chk("extra_byte", k, nwords*4);
        end
      end
      bus.iready = bp ? pat[c % 4] : 1'b1;
      bus.istart = (c == inj_c) || (seen && inj_done);
      if (bus.istart) begin
        bus.ibase = 32'h0000_0040;
        bus.ilen  = 16'd9;
      end
      hold = bus.ovalid && !bus.iready;
      pdat = bus.odat;
      if (bus.ovalid && bus.iready) k++;
      step();
      c++;
    end
    bus.istart = 1'b0;
    bus.iready = 1'b1;
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("byte_count", k, nwords*4);
    chk("post_done", {31'd0, bus.odone}, 32'd0);
    chk("post_busy", {31'd0, bus.obusy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.istart = 1'b0;
    bus.ibase  = 32'h0;
    bus.ilen   = 16'h0;
    bus.iready = 1'b1;
    @(negedge clk);

    // Reset values
    step();
    step();
    chk("rst_addr", bus.ordaddr, 32'h0);
    chk("rst_dat", {24'd0, bus.odat}, 32'h0);
    chk("rst_valid", {31'd0, bus.ovalid}, 32'd0);
    chk("rst_busy", {31'd0, bus.obusy}, 32'd0);
    chk("rst_done", {31'd0, bus.odone}, 32'd0);
    chk("rst_state", {29'd0, dut.r_state}, 32'd0);
    rst = 1'b0;
    step();

    // Single word
    set_word(0, 32'h0);
    start(32'h0, 16'd1);
    chk("req_busy", {31'd0, bus.obusy}, 32'd1);
    chk("req_valid", {31'd0, bus.ovalid}, 32'd0);
    collect(1, 1'b0, -1, 1'b0, 6);

    // Three words, full throughput
    set_word(0, 32'h0); set_word(1, 32'h1); set_word(2, 32'h2);
    start(32'h0, 16'd3);
    collect(3, 1'b0, -1, 1'b0, 18);

    // Three words under backpressure
    start(32'h0, 16'd3);
    collect(3, 1'b1, -1, 1'b0, -1);

    // Zero length: done next cycle, address untouched, no valid
    start(32'h0000_0100, 16'd0);
    chk("z_done", {31'd0, bus.odone}, 32'd1);
    chk("z_busy", {31'd0, bus.obusy}, 32'd0);
    chk("z_valid", {31'd0, bus.ovalid}, 32'd0);
    chk("z_addr", bus.ordaddr, 32'h2);
    step();
    chk("z_done_end", {31'd0, bus.odone}, 32'd0);
    chk("z_valid2", {31'd0, bus.ovalid}, 32'd0);

    // Address wrap
    set_word(0, 32'hFFFF_FFFF); set_word(1, 32'h0);
    start(32'hFFFF_FFFF, 16'd2);
    collect(2, 1'b0, -1, 1'b0, 12);

    // Start pulses while busy and in DONE are ignored
    set_word(0, 32'h0); set_word(1, 32'h1); set_word(2, 32'h2);
    start(32'h0, 16'd3);
    collect(3, 1'b0, 5, 1'b1, 18);
    step();
    chk("ign_busy", {31'd0, bus.obusy}, 32'd0);

    // Abort during the second word
    start(32'h0, 16'd3);
    for (int i = 0; i < 8; i++) step();
    chk("ab_valid", {31'd0, bus.ovalid}, 32'd1);
    chk("ab_dat", {24'd0, bus.odat}, 32'h11);
    chk("ab_addr", bus.ordaddr, 32'h1);
    rst = 1'b1;
    step();
    chk("ab_rst_addr", bus.ordaddr, 32'h0);
    chk("ab_rst_dat", {24'd0, bus.odat}, 32'h0);
    chk("ab_rst_valid", {31'd0, bus.ovalid}, 32'd0);
    chk("ab_rst_busy", {31'd0, bus.obusy}, 32'd0);
    chk("ab_rst_done", {31'd0, bus.odone}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ab_no_done", {31'd0, bus.odone}, 32'd0);
      chk("ab_no_valid", {31'd0, bus.ovalid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
